// File: rtl/alarm_clock_multi.sv
// alarm_clock_multi: 24-hour timekeeper with NUM_ALARMS alarm slots, snooze,
// auto-timeout ringing and an optional 12-hour display format.
// Ports:
//   clk, rst                  system clock, synchronous active-high reset
//   btn_mode/next/up/down/snooze  single-cycle debounced button pulses
//   mode_12h                  display-only 12-hour format select
//   hr_tens..min_units        BCD display digits (time, or alarm edit_idx)
//   seconds                   binary seconds 0..59
//   pm                        12-hour mode and displayed hour >= 12
//   show_alarm, edit_field, edit_idx   edit status
//   alarm_en                  per-slot alarm enable
//   ringing, ring_idx, buzzer ring status (ring_idx 7 = snooze)
//   sec_tick                  one-cycle 1 Hz pulse
module alarm_clock_multi #(
   parameter int unsigned CLK_HZ     = 100000000,
   parameter int unsigned NUM_ALARMS = 4,
   parameter int unsigned SNOOZE_MIN = 5,
   parameter int unsigned RING_SEC   = 60
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  btn_mode,
   input  logic                  btn_next,
   input  logic                  btn_up,
   input  logic                  btn_down,
   input  logic                  btn_snooze,
   input  logic                  mode_12h,
   output logic [1:0]            hr_tens,
   output logic [3:0]            hr_units,
   output logic [2:0]            min_tens,
   output logic [3:0]            min_units,
   output logic [5:0]            seconds,
   output logic                  pm,
   output logic                  show_alarm,
   output logic [1:0]            edit_field,
   output logic [2:0]            edit_idx,
   output logic [NUM_ALARMS-1:0] alarm_en,
   output logic                  ringing,
   output logic [2:0]            ring_idx,
   output logic                  buzzer,
   output logic                  sec_tick
);

   localparam int unsigned PW       = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam int unsigned MAX_A    = 8;
   localparam logic [PW-1:0] PRE_TC = PW'(CLK_HZ - 1);
   localparam logic [7:0]  RING_TC  = 8'(RING_SEC - 1);
   localparam logic [10:0] SNZ_OFS  = 11'(SNOOZE_MIN);
   localparam logic [2:0]  LAST_IDX = 3'(NUM_ALARMS - 1);

   typedef enum logic [2:0] {
      S_RUN, S_SET_HR, S_SET_MIN, S_ALM_HR, S_ALM_MIN, S_RING
   } state_e;

   state_e                  state_q, state_d;
   logic [PW-1:0]           presc_q;
   logic                    tick_q;
   logic                    tick_w;
   logic [4:0]              hr_q, hr_d;
   logic [5:0]              min_q, min_d, sec_q, sec_d;
   logic [MAX_A-1:0][4:0]   ahr_q, ahr_d;
   logic [MAX_A-1:0][5:0]   amin_q, amin_d;
   logic [MAX_A-1:0]        en_q, en_d;
   logic [2:0]              idx_q, idx_d;
   logic [2:0]              ring_idx_q, ring_idx_d;
   logic [7:0]              rcnt_q, rcnt_d;
   logic                    snz_q, snz_d;
   logic [10:0]             snz_tgt_q, snz_tgt_d;

   logic [10:0]             mod_d;
   logic [10:0]             snz_sum;
   logic                    at_zero;
   logic                    hit;
   logic [2:0]              hit_idx;
   logic                    any_btn;

   logic [4:0]              disp_hr, disp_hr12;
   logic [5:0]              disp_min;

   function automatic logic [4:0] hr_step(input logic [4:0] v, input logic up);
      if (up) return (v == 5'd23) ? 5'd0 : v + 5'd1;
      else    return (v == 5'd0) ? 5'd23 : v - 5'd1;
   endfunction

   function automatic logic [5:0] min_step(input logic [5:0] v, input logic up);
      if (up) return (v == 6'd59) ? 6'd0 : v + 6'd1;
      else    return (v == 6'd0) ? 6'd59 : v - 6'd1;
   endfunction

   assign tick_w  = (presc_q == PRE_TC);
   assign any_btn = btn_mode | btn_next | btn_up | btn_down | btn_snooze;

   // Next-state, time advance, edits and match detection
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      ring_idx_d = ring_idx_q;
      rcnt_d     = rcnt_q;
      snz_d      = snz_q;
      snz_tgt_d  = snz_tgt_q;
      ahr_d      = ahr_q;
      amin_d     = amin_q;
      en_d       = en_q;
      hr_d       = hr_q;
      min_d      = min_q;
      sec_d      = sec_q;
      hit        = 1'b0;
      hit_idx    = 3'd0;

      // Post-tick time; clock edit freezes time with seconds at zero
      if (state_q == S_SET_HR || state_q == S_SET_MIN) begin
         sec_d = 6'd0;
      end else if (tick_w) begin
         if (sec_q == 6'd59) begin
            sec_d = 6'd0;
            if (min_q == 6'd59) begin
               min_d = 6'd0;
               hr_d  = (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
            end else begin
               min_d = min_q + 6'd1;
            end
         end else begin
            sec_d = sec_q + 6'd1;
         end
      end

      mod_d   = 11'(hr_d) * 11'd60 + 11'(min_d);
      at_zero = tick_w && (sec_d == 6'd0);
      snz_sum = mod_d + SNZ_OFS;

      // Reverse scan so the lowest matching slot wins
      for (int i = int'(NUM_ALARMS) - 1; i >= 0; i--) begin
         if (en_q[i] && ahr_q[i] == hr_d && amin_q[i] == min_d) begin
            hit     = 1'b1;
            hit_idx = 3'(i);
         end
      end

      case (state_q)
         S_RUN: begin
            if (at_zero && (hit || (snz_q && mod_d == snz_tgt_q))) begin
               state_d    = S_RING;
               ring_idx_d = hit ? hit_idx : 3'd7;
               rcnt_d     = 8'd0;
            end else if (btn_mode) begin
               state_d = S_SET_HR;
               idx_d   = 3'd0;
            end
         end
         S_SET_HR, S_SET_MIN, S_ALM_HR, S_ALM_MIN: begin
            if (btn_mode) begin
               state_d = S_RUN;
               idx_d   = 3'd0;
            end else if (btn_next) begin
               case (state_q)
                  S_SET_HR:  state_d = S_SET_MIN;
                  S_SET_MIN: begin
                     state_d = S_ALM_HR;
                     idx_d   = 3'd0;
                  end
                  S_ALM_HR:  state_d = S_ALM_MIN;
                  default: begin
                     if (idx_q == LAST_IDX) begin
                        state_d = S_SET_HR;
                        idx_d   = 3'd0;
                     end else begin
                        state_d = S_ALM_HR;
                        idx_d   = idx_q + 3'd1;
                     end
                  end
               endcase
            end else if (btn_up || btn_down) begin
               case (state_q)
                  S_SET_HR:  hr_d = hr_step(hr_d, btn_up);
                  S_SET_MIN: min_d = min_step(min_d, btn_up);
                  S_ALM_HR:  ahr_d[idx_q] = hr_step(ahr_q[idx_q], btn_up);
                  default:   amin_d[idx_q] = min_step(amin_q[idx_q], btn_up);
               endcase
            end else if (btn_snooze && (state_q == S_ALM_HR || state_q == S_ALM_MIN)) begin
               en_d[idx_q] = ~en_q[idx_q];
            end
         end
         S_RING: begin
            // A button outranks the timeout when both land in one cycle
            if (any_btn) begin
               state_d = S_RUN;
               if (btn_snooze) begin
                  snz_d     = 1'b1;
                  snz_tgt_d = (snz_sum >= 11'd1440) ? snz_sum - 11'd1440 : snz_sum;
               end else begin
                  snz_d = 1'b0;
               end
            end else if (tick_w) begin
               if (rcnt_q == RING_TC) begin
                  state_d = S_RUN;
                  snz_d   = 1'b0;
               end else begin
                  rcnt_d = rcnt_q + 8'd1;
               end
            end
         end
         default: state_d = S_RUN;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_RUN;
         presc_q    <= '0;
         tick_q     <= 1'b0;
         hr_q       <= 5'd0;
         min_q      <= 6'd0;
         sec_q      <= 6'd0;
         ahr_q      <= '0;
         amin_q     <= '0;
         en_q       <= '0;
         idx_q      <= 3'd0;
         ring_idx_q <= 3'd0;
         rcnt_q     <= 8'd0;
         snz_q      <= 1'b0;
         snz_tgt_q  <= 11'd0;
      end else begin
         state_q    <= state_d;
         presc_q    <= tick_w ? '0 : presc_q + PW'(1);
         tick_q     <= tick_w;
         hr_q       <= hr_d;
         min_q      <= min_d;
         sec_q      <= sec_d;
         ahr_q      <= ahr_d;
         amin_q     <= amin_d;
         en_q       <= en_d;
         idx_q      <= idx_d;
         ring_idx_q <= ring_idx_d;
         rcnt_q     <= rcnt_d;
         snz_q      <= snz_d;
         snz_tgt_q  <= snz_tgt_d;
      end
   end

   assign show_alarm = (state_q == S_ALM_HR) || (state_q == S_ALM_MIN);
   assign edit_field = (state_q == S_SET_HR  || state_q == S_ALM_HR)  ? 2'd1 :
                       (state_q == S_SET_MIN || state_q == S_ALM_MIN) ? 2'd2 : 2'd0;
   assign edit_idx   = idx_q;
   assign alarm_en   = en_q[NUM_ALARMS-1:0];
   assign ringing    = (state_q == S_RING);
   assign ring_idx   = ring_idx_q;
   assign buzzer     = ringing & ~sec_q[0];
   assign sec_tick   = tick_q;
   assign seconds    = sec_q;

   // Display source select and 12-hour mapping
   always_comb begin
      disp_hr   = show_alarm ? ahr_q[idx_q]  : hr_q;
      disp_min  = show_alarm ? amin_q[idx_q] : min_q;
      disp_hr12 = disp_hr;
      if (mode_12h) begin
         if (disp_hr == 5'd0)       disp_hr12 = 5'd12;
         else if (disp_hr > 5'd12)  disp_hr12 = disp_hr - 5'd12;
      end
   end

   assign pm        = mode_12h & (disp_hr >= 5'd12);
   assign hr_tens   = 2'(disp_hr12 / 5'd10);
   assign hr_units  = 4'(disp_hr12 % 5'd10);
   assign min_tens  = 3'(disp_min / 6'd10);
   assign min_units = 4'(disp_min % 6'd10);

endmodule

// File: tb/tb_alarm_clock_multi.sv
// Randomised/directed bench for alarm_clock_multi against a seconds-of-day model.
module tb_alarm_clock_multi;

   localparam int CLK_HZ = 4;
   localparam int NA     = 4;
   localparam int SNZ    = 5;
   localparam int RSEC   = 3;

   localparam logic [4:0] B_NONE = 5'b00000;
   localparam logic [4:0] B_MODE = 5'b10000;
   localparam logic [4:0] B_NEXT = 5'b01000;
   localparam logic [4:0] B_UP   = 5'b00100;
   localparam logic [4:0] B_DOWN = 5'b00010;
   localparam logic [4:0] B_SNZ  = 5'b00001;

   logic clk, rst, btn_mode, btn_next, btn_up, btn_down, btn_snooze, mode_12h;
   logic [1:0]    hr_tens;
   logic [3:0]    hr_units;
   logic [2:0]    min_tens;
   logic [3:0]    min_units;
   logic [5:0]    seconds;
   logic          pm, show_alarm;
   logic [1:0]    edit_field;
   logic [2:0]    edit_idx;
   logic [NA-1:0] alarm_en;
   logic          ringing;
   logic [2:0]    ring_idx;
   logic          buzzer, sec_tick;

   alarm_clock_multi #(.CLK_HZ(CLK_HZ), .NUM_ALARMS(NA), .SNOOZE_MIN(SNZ), .RING_SEC(RSEC)) dut (
      .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_next(btn_next), .btn_up(btn_up),
      .btn_down(btn_down), .btn_snooze(btn_snooze), .mode_12h(mode_12h),
      .hr_tens(hr_tens), .hr_units(hr_units), .min_tens(min_tens), .min_units(min_units),
      .seconds(seconds), .pm(pm), .show_alarm(show_alarm), .edit_field(edit_field),
      .edit_idx(edit_idx), .alarm_en(alarm_en), .ringing(ringing), .ring_idx(ring_idx),
      .buzzer(buzzer), .sec_tick(sec_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
   endtask

   // Model: time as seconds-of-day, alarms as minute-of-day, edit position as
   // a linear index over the edit cycle (0 clock hr, 1 clock min, 2+2i / 3+2i slot i).
   int m_presc, m_tod, m_mode, m_pos, m_ring_slot, m_ring_ticks, m_snz_tgt;
   int m_alm [NA];
   bit m_en [NA];
   bit m_snz, m_tick, m12;

   task automatic model_reset();
      m_presc = 0; m_tod = 0; m_mode = 0; m_pos = 0;
      m_ring_slot = 0; m_ring_ticks = 0; m_snz = 0; m_snz_tgt = 0; m_tick = 0;
      for (int i = 0; i < NA; i++) begin
         m_alm[i] = 0;
         m_en[i]  = 0;
      end
   endtask

   task automatic model_step();
      int nm, hit, d, slot, h, mi;
      if (rst) begin
         model_reset();
         return;
      end
      m_tick  = (m_presc == CLK_HZ - 1);
      m_presc = m_tick ? 0 : m_presc + 1;
      if (m_mode == 1 && m_pos < 2) m_tod = m_tod - (m_tod % 60);
      else if (m_tick)              m_tod = (m_tod + 1) % 86400;
      nm = m_tod / 60;
      d  = btn_up ? 1 : -1;
      if (m_mode == 0) begin
         hit = -1;
         if (m_tick && (m_tod % 60) == 0) begin
            for (int i = 0; i < NA; i++)
               if (hit < 0 && m_en[i] && m_alm[i] == nm) hit = i;
            if (hit < 0 && m_snz && m_snz_tgt == nm) hit = 7;
         end
         if (hit >= 0) begin
            m_mode = 2; m_ring_slot = hit; m_ring_ticks = 0;
         end else if (btn_mode) begin
            m_mode = 1; m_pos = 0;
         end
      end else if (m_mode == 1) begin
         slot = (m_pos - 2) / 2;
         if (btn_mode) begin
            m_mode = 0; m_pos = 0;
         end else if (btn_next) begin
            m_pos = (m_pos + 1) % (2 + 2 * NA);
         end else if (btn_up || btn_down) begin
            if (m_pos < 2) begin
               h = m_tod / 3600; mi = (m_tod / 60) % 60;
               if (m_pos == 0) h = (h + 24 + d) % 24; else mi = (mi + 60 + d) % 60;
               m_tod = h * 3600 + mi * 60 + (m_tod % 60);
            end else begin
               h = m_alm[slot] / 60; mi = m_alm[slot] % 60;
               if (m_pos % 2 == 0) h = (h + 24 + d) % 24; else mi = (mi + 60 + d) % 60;
               m_alm[slot] = h * 60 + mi;
            end
         end else if (btn_snooze && m_pos >= 2) begin
            m_en[slot] = !m_en[slot];
         end
      end else begin
         if (btn_mode || btn_next || btn_up || btn_down || btn_snooze) begin
            m_mode = 0;
            if (btn_snooze) begin
               m_snz = 1; m_snz_tgt = (nm + SNZ) % 1440;
            end else begin
               m_snz = 0;
            end
         end else if (m_tick) begin
            m_ring_ticks++;
            if (m_ring_ticks == RSEC) begin
               m_mode = 0; m_snz = 0;
            end
         end
      end
   endtask

   task automatic compare_all();
      int dh, dm, slot, efield;
      bit show;
      logic [NA-1:0] ev;
      show = (m_mode == 1) && (m_pos >= 2);
      slot = show ? (m_pos - 2) / 2 : 0;
      dh = show ? m_alm[slot] / 60 : m_tod / 3600;
      dm = show ? m_alm[slot] % 60 : (m_tod / 60) % 60;
      efield = (m_mode == 1) ? ((m_pos % 2 == 0) ? 1 : 2) : 0;
      for (int i = 0; i < NA; i++) ev[i] = m_en[i];
      chk("pm", 32'(pm), 32'(m12 && dh >= 12));
      if (m12) dh = (dh == 0) ? 12 : (dh > 12 ? dh - 12 : dh);
      chk("hr_tens",    32'(hr_tens),    dh / 10);
      chk("hr_units",   32'(hr_units),   dh % 10);
      chk("min_tens",   32'(min_tens),   dm / 10);
      chk("min_units",  32'(min_units),  dm % 10);
      chk("seconds",    32'(seconds),    m_tod % 60);
      chk("show_alarm", 32'(show_alarm), 32'(show));
      chk("edit_field", 32'(edit_field), efield);
      chk("edit_idx",   32'(edit_idx),   slot);
      chk("alarm_en",   32'(alarm_en),   32'(ev));
      chk("ringing",    32'(ringing),    32'(m_mode == 2));
      chk("ring_idx",   32'(ring_idx),   m_ring_slot);
      chk("buzzer",     32'(buzzer),     32'(m_mode == 2 && (m_tod % 2) == 0));
      chk("sec_tick",   32'(sec_tick),   32'(m_tick));
   endtask

   task automatic cycle(input logic [4:0] btns, input bit r);
      {btn_mode, btn_next, btn_up, btn_down, btn_snooze} = btns;
      mode_12h = m12;
      rst = r;
      @(posedge clk);
      model_step();
      #1;
      compare_all();
      {btn_mode, btn_next, btn_up, btn_down, btn_snooze} = B_NONE;
   endtask

   task automatic press(input logic [4:0] b);
      cycle(b, 1'b0);
   endtask

   task automatic idle(input int n);
      repeat (n) cycle(B_NONE, 1'b0);
   endtask

   function automatic int cur_field();
      if (m_pos == 0) return m_tod / 3600;
      if (m_pos == 1) return (m_tod / 60) % 60;
      if (m_pos % 2 == 0) return m_alm[(m_pos - 2) / 2] / 60;
      return m_alm[(m_pos - 2) / 2] % 60;
   endfunction

   task automatic goto_pos(input int p);
      for (int k = 0; k < 60; k++) begin
         if (m_mode == 2)      press(B_DOWN);
         else if (m_mode == 0) press(B_MODE);
         else if (m_pos != p)  press(B_NEXT);
         else break;
      end
   endtask

   task automatic set_field(input int target);
      for (int k = 0; k < 70; k++) begin
         if (cur_field() == target) break;
         press(B_UP);
      end
   endtask

   task automatic to_run();
      for (int k = 0; k < 5; k++) begin
         if (m_mode == 0) break;
         press(m_mode == 2 ? B_DOWN : B_MODE);
      end
   endtask

   task automatic set_time(input int h, input int mi);
      goto_pos(0); set_field(h);
      goto_pos(1); set_field(mi);
      to_run();
   endtask

   task automatic set_alarm(input int slot, input int h, input int mi, input bit en);
      goto_pos(2 + 2 * slot); set_field(h);
      goto_pos(3 + 2 * slot); set_field(mi);
      if (m_en[slot] != en) press(B_SNZ);
      to_run();
   endtask

   task automatic wait_ring(input int max, input string tag);
      for (int k = 0; k < max; k++) begin
         if (m_mode == 2) break;
         idle(1);
      end
      chk(tag, 32'(ringing), 32'd1);
   endtask

   function automatic int disp_hr();
      return 32'(hr_tens) * 10 + 32'(hr_units);
   endfunction

   function automatic int disp_min();
      return 32'(min_tens) * 10 + 32'(min_units);
   endfunction

   initial begin
      int t, r;
      logic [4:0] pick [5];
      pick[0] = B_MODE; pick[1] = B_NEXT; pick[2] = B_UP; pick[3] = B_DOWN; pick[4] = B_SNZ;
      {btn_mode, btn_next, btn_up, btn_down, btn_snooze} = B_NONE;
      m12 = 1'b0; mode_12h = 1'b0; rst = 1'b1;
      model_reset();

      repeat (3) cycle(B_NONE, 1'b1);
      idle(8);

      // Midnight rollover
      set_time(23, 59);
      idle(61 * CLK_HZ);
      chk("rollover_hr", disp_hr(), 0);

      // Hour down-wrap and minute up-wrap without carry
      set_time(0, 59);
      goto_pos(0);
      repeat (3) press(B_DOWN);
      chk("hr_down3", disp_hr(), 21);
      press(B_NEXT);
      press(B_UP);
      chk("min_wrap", disp_min(), 0);
      chk("hr_kept", disp_hr(), 21);
      to_run();

      // Two slots on one minute: lowest wins, then snooze
      set_time(0, 0);
      set_alarm(2, 0, 2, 1'b1);
      set_alarm(1, 0, 2, 1'b1);
      wait_ring(200 * CLK_HZ, "alarm_ring");
      chk("alarm_ring_idx", 32'(ring_idx), 32'd1);
      idle(CLK_HZ + 1);
      press(B_SNZ);
      chk("snooze_exit", 32'(ringing), 32'd0);
      wait_ring(7 * 60 * CLK_HZ, "snooze_ring");
      chk("snooze_ring_idx", 32'(ring_idx), 32'd7);
      chk("snooze_min", disp_min(), 7);
      idle((RSEC + 2) * CLK_HZ);
      chk("timeout", 32'(ringing), 32'd0);
      idle(70 * CLK_HZ);

      // 12-hour display
      m12 = 1'b1;
      set_time(0, 30);
      idle(1);
      chk("h12_zero", disp_hr(), 12);
      chk("h12_zero_pm", 32'(pm), 32'd0);
      set_time(13, 5);
      idle(1);
      chk("h12_13", disp_hr(), 1);
      chk("h12_13_pm", 32'(pm), 32'd1);

      // Reset mid-ring
      t = (m_tod / 60 + 2) % 1440;
      set_alarm(0, t / 60, t % 60, 1'b1);
      wait_ring(4 * 60 * CLK_HZ, "ring0");
      idle(2);
      cycle(B_NONE, 1'b1);
      chk("rst_ringing", 32'(ringing), 32'd0);
      chk("rst_alarm_en", 32'(alarm_en), 32'd0);
      idle(3);

      // Random buttons around live alarms
      set_alarm(3, 0, 3, 1'b1);
      set_alarm(0, 0, 3, 1'b1);
      for (int k = 0; k < 4000; k++) begin
         r = int'($urandom_range(0, 99));
         if ($urandom_range(0, 199) == 0) m12 = !m12;
         if (r < 8) press(pick[$urandom_range(0, 4)]);
         else idle(1);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: run did not complete, %0d/%0d checks passed", n_pass, n_chk);
      $fatal(1);
   end

endmodule
